// File: rtl/ifu_fetch_if.sv
// Handshake bundle for the fetch stage: instruction-memory request/response
// channels plus the {pc, inst} valid/ready channel toward decode.
// master = fetch unit side, slave = memory/decode side (testbench or neighbours).
interface ifu_fetch_if;
   // instruction-memory request channel
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_req_addr;
   // instruction-memory response channel
   logic        mem_rsp_valid;
   logic        mem_rsp_ready;
   logic [31:0] mem_rsp_data;
   // channel toward decode
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;

   modport master (
      output mem_req_valid, mem_req_addr, mem_rsp_ready, out_valid, out_pc, out_inst,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready
   );

   modport slave (
      input  mem_req_valid, mem_req_addr, mem_rsp_ready, out_valid, out_pc, out_inst,
      output mem_req_ready, mem_rsp_valid, mem_rsp_data, out_ready
   );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch: one outstanding word fetch, static prediction, 1-entry out buffer.
// Latency: request one cycle after the previous response; out_valid the cycle after rsp.
// Backpressure: mem_rsp_ready drops while the buffer is full and decode is stalled.
// Ports: clock/reset (sync, active-high); flush/flush_dnpc and jump_flush/jump_dnpc
// redirects (flush wins); bus = memory req/rsp + decode {pc, inst} handshakes.
module ifu_fetch #(
   parameter logic [31:0] RESET_PC = 32'h3000_0000
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         flush,
   input  logic [31:0]  flush_dnpc,
   input  logic         jump_flush,
   input  logic [31:0]  jump_dnpc,
   ifu_fetch_if.master  bus
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t      state_q;
   logic [31:0] pc_q;        // address the next fresh request must use
   logic [31:0] req_addr_q;  // address on the bus / of the outstanding request
   logic        discard_q;   // outstanding or pending request is stale
   logic        buf_valid_q;
   logic [31:0] buf_pc_q;
   logic [31:0] buf_inst_q;

   logic        redirect;
   logic [31:0] target;
   logic        req_fire;
   logic        rsp_fire;
   logic        out_fire;
   logic [31:0] imm_j;
   logic [31:0] imm_b;
   logic [31:0] pred_pc;

   assign redirect = flush | jump_flush;
   assign target   = flush ? flush_dnpc : jump_dnpc;

   assign bus.mem_req_valid = (state_q == REQ);
   assign bus.mem_req_addr  = req_addr_q;
   // Only meaningful while a response is awaited; held low elsewhere.
   assign bus.mem_rsp_ready = (state_q == WAIT) & (discard_q | ~buf_valid_q | bus.out_ready);
   assign bus.out_valid     = buf_valid_q & ~redirect;
   assign bus.out_pc        = buf_pc_q;
   assign bus.out_inst      = buf_inst_q;

   assign req_fire = bus.mem_req_valid & bus.mem_req_ready;
   assign rsp_fire = bus.mem_rsp_valid & bus.mem_rsp_ready;
   assign out_fire = bus.out_valid & bus.out_ready;

   // Static prediction on the returned word, relative to its request address.
   assign imm_j = {{11{bus.mem_rsp_data[31]}}, bus.mem_rsp_data[31], bus.mem_rsp_data[19:12],
                   bus.mem_rsp_data[20], bus.mem_rsp_data[30:21], 1'b0};
   assign imm_b = {{19{bus.mem_rsp_data[31]}}, bus.mem_rsp_data[31], bus.mem_rsp_data[7],
                   bus.mem_rsp_data[30:25], bus.mem_rsp_data[11:8], 1'b0};

   always_comb begin
      pred_pc = req_addr_q + 32'd4;
      if (bus.mem_rsp_data[6:2] == 5'b11011)
         pred_pc = req_addr_q + imm_j;
      else if (bus.mem_rsp_data[6:2] == 5'b11000 && bus.mem_rsp_data[31])
         pred_pc = req_addr_q + imm_b;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         req_addr_q  <= RESET_PC;
         discard_q   <= 1'b0;
         buf_valid_q <= 1'b0;
         buf_pc_q    <= '0;
         buf_inst_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q    <= REQ;
               req_addr_q <= redirect ? target : pc_q;
            end
            REQ: begin
               // Address stays put even across a redirect; the response gets dropped.
               if (req_fire)
                  state_q <= WAIT;
            end
            WAIT: begin
               if (rsp_fire) begin
                  state_q <= REQ;
                  if (redirect)
                     req_addr_q <= target;
                  else if (discard_q)
                     req_addr_q <= pc_q;
                  else
                     req_addr_q <= pred_pc;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (redirect)
            pc_q <= target;
         else if (rsp_fire && !discard_q)
            pc_q <= pred_pc;

         // A request still pending or in flight after this edge belongs to the old path.
         if (redirect && ((state_q == REQ) || (state_q == WAIT && !rsp_fire)))
            discard_q <= 1'b1;
         else if (rsp_fire)
            discard_q <= 1'b0;

         if (rsp_fire && !discard_q && !redirect) begin
            buf_valid_q <= 1'b1;
            buf_pc_q    <= req_addr_q;
            buf_inst_q  <= bus.mem_rsp_data;
         end else if (redirect || out_fire) begin
            buf_valid_q <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: randomized memory/decode/redirect stimulus against an
// instruction-stream model (expected fetch pc + queue of deliverable words),
// plus directed phases pinning literal address/pc sequences.
module tb_ifu_fetch;
   localparam logic [31:0] RST_PC = 32'h3000_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        flush = 1'b0;
   logic        jump_flush = 1'b0;
   logic [31:0] flush_dnpc = '0;
   logic [31:0] jump_dnpc = '0;

   always #5 clk = ~clk;

   ifu_fetch_if bus();

   ifu_fetch #(.RESET_PC(RST_PC)) dut (
      .clock      (clk),
      .reset      (reset),
      .flush      (flush),
      .flush_dnpc (flush_dnpc),
      .jump_flush (jump_flush),
      .jump_dnpc  (jump_dnpc),
      .bus        (bus)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // stimulus knobs
   int p_rdy, p_out, p_fl, lat_max;
   bit straight;
   // memory model
   bit          mem_busy, rsp_done;
   logic [31:0] mem_addr;
   int          mem_lat;
   // directed trigger: after a fresh request to trig_addr is accepted, force a redirect
   bit          trig_arm, force_next, force_fl, force_jf;
   logic [31:0] trig_addr, force_fd, force_jd;
   // reference model
   logic [31:0] exp_pc, out_addr, held_addr;
   bit          outst, out_stale, pend_stale, held;
   int          idle;
   ent_t        mq[$];
   logic [31:0] acc_q[$];
   logic [31:0] del_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_cmp++;
      n_bad++;
      $display("FAIL %s: event missing", nm);
   endtask

   task automatic lit(input string nm, input logic [31:0] q[$], input int i, input logic [31:0] v);
      if (q.size() > i) chk(nm, q[i], v);
      else fail(nm);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [31:0] h;
      if (straight) return 32'h0000_0013;              // addi x0,x0,0
      case (a)
         32'h3000_0000: return 32'h0100_006F;           // jal x0,+16
         32'h3000_0010: return 32'hFE00_0EE3;           // beq backward, -4
         32'h3000_000C: return 32'h0000_0463;           // beq forward, +8
         default: ;
      endcase
      h = (a * 32'h9E37_79B1) ^ (a >> 7);
      case (h[31:29])
         3'd0, 3'd1: return 32'h0010_0093;              // addi
         3'd2:       return 32'h0020_8463;              // forward branch
         3'd3:       return 32'hFE00_0CE3;              // backward branch, -8
         3'd4:       return 32'h0080_006F;              // jal +8
         3'd5:       return 32'h0100_006F;              // jal +16
         default:    return h;                          // arbitrary word
      endcase
   endfunction

   // Next fetch address from the instruction rules (jal taken, backward branch taken).
   function automatic logic [31:0] predict(input logic [31:0] pc, input logic [31:0] w);
      logic signed [20:0] j;
      logic signed [12:0] b;
      int off;
      j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
      b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
      off = 4;
      if (w[6:2] == 5'b11011) off = int'(j);
      else if (w[6:2] == 5'b11000 && w[31]) off = int'(b);
      return pc + off;
   endfunction

   task automatic drive();
      bus.mem_req_ready = ($urandom_range(0, 99) < p_rdy);
      if (rsp_done) begin
         bus.mem_rsp_valid = 1'b0;
         rsp_done = 1'b0;
      end
      if (mem_busy && !bus.mem_rsp_valid) begin
         if (mem_lat == 0) begin
            bus.mem_rsp_valid = 1'b1;
            bus.mem_rsp_data  = mem_word(mem_addr);
         end else begin
            mem_lat--;
         end
      end
      bus.out_ready = ($urandom_range(0, 99) < p_out);
      if (force_next) begin
         flush = force_fl; jump_flush = force_jf;
         flush_dnpc = force_fd; jump_dnpc = force_jd;
         force_next = 1'b0;
      end else begin
         flush      = ($urandom_range(0, 999) < p_fl);
         jump_flush = ($urandom_range(0, 999) < p_fl);
         flush_dnpc = RST_PC + ($urandom_range(0, 255) << 2);
         jump_dnpc  = RST_PC + ($urandom_range(0, 255) << 2);
      end
   endtask

   task automatic model();
      bit rf, sf, of, rd, was_pend, ov;
      logic [31:0] tg;
      // --- checks against current model state
      ov = (mq.size() > 0) && !flush && !jump_flush;
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, ov});
      if (ov) begin
         chk("out_pc", bus.out_pc, mq[0].pc);
         chk("out_inst", bus.out_inst, mq[0].inst);
      end
      if (outst) begin
         chk("one_outstanding", {31'd0, bus.mem_req_valid}, 32'd0);
         chk("rsp_ready", {31'd0, bus.mem_rsp_ready},
             {31'd0, out_stale || mq.size() == 0 || bus.out_ready});
      end
      if (held) begin
         chk("req_held_valid", {31'd0, bus.mem_req_valid}, 32'd1);
         chk("req_held_addr", bus.mem_req_addr, held_addr);
      end
      if (bus.mem_req_valid && !outst && !pend_stale)
         chk("req_addr", bus.mem_req_addr, exp_pc);
      if (idle > 64) begin
         fail("progress");
         idle = 0;
      end
      // --- advance the model through the coming edge
      rf = bus.mem_req_valid && bus.mem_req_ready;
      sf = bus.mem_rsp_valid && bus.mem_rsp_ready;
      of = bus.out_valid && bus.out_ready;
      rd = flush || jump_flush;
      tg = flush ? flush_dnpc : jump_dnpc;
      was_pend = pend_stale;
      if (of && mq.size() > 0) void'(mq.pop_front());
      if (sf) begin
         outst = 1'b0;
         if (!out_stale && !rd) begin
            mq.push_back('{pc: out_addr, inst: mem_word(out_addr)});
            del_q.push_back(out_addr);
            exp_pc = predict(out_addr, mem_word(out_addr));
         end
      end
      if (rf) begin
         outst = 1'b1;
         out_addr = bus.mem_req_addr;
         out_stale = pend_stale || rd;
         if (!pend_stale) acc_q.push_back(bus.mem_req_addr);
         pend_stale = 1'b0;
      end
      if (rd) begin
         exp_pc = tg;
         mq.delete();
         if (outst) out_stale = 1'b1;
         if (bus.mem_req_valid && !bus.mem_req_ready) pend_stale = 1'b1;
      end
      held = bus.mem_req_valid && !bus.mem_req_ready;
      held_addr = bus.mem_req_addr;
      // --- memory bookkeeping
      if (rf) begin
         mem_busy = 1'b1;
         mem_addr = bus.mem_req_addr;
         mem_lat  = $urandom_range(0, lat_max);
         idle = 0;
         if (trig_arm && !was_pend && bus.mem_req_addr == trig_addr) begin
            trig_arm = 1'b0;
            force_next = 1'b1;
         end
      end else begin
         idle++;
      end
      if (sf) begin
         mem_busy = 1'b0;
         rsp_done = 1'b1;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1 drive();
      @(negedge clk);
      model();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
      flush = 1'b0; jump_flush = 1'b0;
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
      bus.out_ready = 1'b0;
      mem_busy = 1'b0; rsp_done = 1'b0; force_next = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("reset_req_valid", {31'd0, bus.mem_req_valid}, 32'd0);
      chk("reset_rsp_ready", {31'd0, bus.mem_rsp_ready}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      exp_pc = RST_PC; outst = 1'b0; out_stale = 1'b0; pend_stale = 1'b0;
      held = 1'b0; idle = 0;
      mq.delete(); acc_q.delete(); del_q.delete();
      @(negedge clk);
      chk("idle_after_reset", {31'd0, bus.mem_req_valid}, 32'd0);
      model();
      step();
      chk("first_req_valid", {31'd0, bus.mem_req_valid}, 32'd1);
      chk("first_req_addr", bus.mem_req_addr, 32'h3000_0000);
   endtask

   initial begin
      bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
      bus.out_ready = 1'b0;
      trig_arm = 1'b0;

      // Straight-line ADDI stream; jump_flush while waiting on 0x30000008.
      straight = 1'b1; p_rdy = 100; p_out = 100; lat_max = 0; p_fl = 0;
      do_reset();
      trig_arm = 1'b1; trig_addr = 32'h3000_0008;
      force_fl = 1'b0; force_jf = 1'b1; force_fd = 32'h0; force_jd = 32'h3000_0100;
      repeat (30) step();
      lit("A_acc0", acc_q, 0, 32'h3000_0000);
      lit("A_acc1", acc_q, 1, 32'h3000_0004);
      lit("A_acc2", acc_q, 2, 32'h3000_0008);
      lit("A_acc3", acc_q, 3, 32'h3000_0100);
      lit("A_del0", del_q, 0, 32'h3000_0000);
      lit("A_del1", del_q, 1, 32'h3000_0004);
      lit("A_del2", del_q, 2, 32'h3000_0100);

      // Prediction: jal +16, backward branch -4, forward branch +4; then flush+jump together.
      straight = 1'b0;
      do_reset();
      trig_arm = 1'b1; trig_addr = 32'h3000_000C;
      force_fl = 1'b1; force_jf = 1'b1; force_fd = 32'h8000_0000; force_jd = 32'h3000_0040;
      repeat (30) step();
      lit("B_acc0", acc_q, 0, 32'h3000_0000);
      lit("B_acc1", acc_q, 1, 32'h3000_0010);
      lit("B_acc2", acc_q, 2, 32'h3000_000C);
      lit("B_acc3", acc_q, 3, 32'h8000_0000);
      lit("B_del1", del_q, 1, 32'h3000_0010);
      lit("B_del2", del_q, 2, 32'h8000_0000);

      // Random traffic with stalls, latency and redirects.
      trig_arm = 1'b0;
      p_rdy = 60; p_out = 60; lat_max = 3; p_fl = 40;
      do_reset();
      repeat (1500) step();

      // Reset mid-operation, then heavy backpressure on both sides.
      p_rdy = 35; p_out = 20; lat_max = 3; p_fl = 20;
      do_reset();
      repeat (1500) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
